// File: rtl/host_network_interface_pkg.sv
// Shared definitions for the root-side host network interface:
// flit layout, type encodings and default sizing.
package host_network_interface_pkg;

    localparam int ROUTER_WIDTH_DEF = 32;
    localparam int TX_CREDITS_DEF   = 4;
    localparam int RX_DEPTH_DEF     = 4;

    localparam int TYPE_LSB = 30;
    localparam int PE_LSB   = 24;
    localparam int AUX_LSB  = 16;
    localparam int DATA_LSB = 0;

    localparam logic [5:0] PE_BROADCAST = 6'h3F;

    typedef enum logic [1:0] {
        FLIT_CFG    = 2'd0,
        FLIT_ACT    = 2'd1,
        FLIT_START  = 2'd2,
        FLIT_OUTACT = 2'd3
    } flit_type_e;

    typedef struct packed {
        logic [1:0]  ftype;
        logic [5:0]  pe;
        logic [7:0]  aux;
        logic [15:0] data;
    } flit_t;

    typedef struct packed {
        logic [5:0]  pe;
        logic [7:0]  idx;
        logic [15:0] data;
    } rx_entry_t;

    function automatic flit_t pack_flit(
        input logic [1:0]  ftype,
        input logic [5:0]  pe,
        input logic [7:0]  aux,
        input logic [15:0] data
    );
        flit_t f;
        f.ftype = ftype;
        f.pe    = pe;
        f.aux   = aux;
        f.data  = data;
        return f;
    endfunction

endpackage

// File: rtl/host_network_interface_rx_fifo.sv
// Receive FIFO holding output-activation entries for the host.
// Write while full is accepted only when a read frees a slot that cycle.
module host_rx_fifo
    import host_network_interface_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int DEPTH = RX_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_wr, do_rd;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    assign do_rd  = rd_en_i && !empty_o;
    assign do_wr  = wr_en_i && (!full_o || do_rd);
    assign wptr_d = wptr_q + (AW+1)'(do_wr);
    assign rptr_d = rptr_q + (AW+1)'(do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/host_network_interface.sv
// Root-side endpoint of the credit-based router tree: credit-gated
// command injection towards the tree, buffered result return to the host.
module host_network_interface
    import host_network_interface_pkg::*;
#(
    parameter int ROUTER_WIDTH = ROUTER_WIDTH_DEF,
    parameter int TX_CREDITS   = TX_CREDITS_DEF,
    parameter int RX_DEPTH     = RX_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    host_tx_valid,
    output logic                    host_tx_ready,
    input  logic [1:0]              host_tx_type,
    input  logic [5:0]              host_tx_pe,
    input  logic [7:0]              host_tx_aux,
    input  logic [15:0]             host_tx_data,
    output logic                    host_rx_valid,
    input  logic                    host_rx_ready,
    output logic [5:0]              host_rx_pe,
    output logic [7:0]              host_rx_idx,
    output logic [15:0]             host_rx_data,
    output logic                    out_data_valid,
    output logic [ROUTER_WIDTH-1:0] out_data,
    input  logic                    downstream_credit,
    input  logic                    in_data_valid,
    input  logic [ROUTER_WIDTH-1:0] in_data,
    output logic                    upstream_credit,
    output logic [1:0]              err
);

    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam int PW = 3;

    logic [CW-1:0]           credit_cnt_q, credit_cnt_d;
    logic                    out_valid_q;
    logic [ROUTER_WIDTH-1:0] out_data_q;
    logic                    up_credit_q, up_credit_d;
    logic [PW-1:0]           pend_q, pend_d, owed;
    logic [1:0]              err_q;
    logic                    accept, cred_ovf;
    flit_t                   in_flit;
    rx_entry_t               wr_entry, head;
    logic                    is_outact, drop, rx_pop, rx_full, rx_empty, rx_ovf;

    assign host_tx_ready = (credit_cnt_q != '0) && (host_tx_type != FLIT_OUTACT);
    assign accept        = host_tx_valid && host_tx_ready;

    always_comb begin
        credit_cnt_d = credit_cnt_q;
        cred_ovf     = 1'b0;
        case ({downstream_credit, accept})
            2'b10: begin
                if (credit_cnt_q == CW'(TX_CREDITS)) cred_ovf = 1'b1;
                else credit_cnt_d = credit_cnt_q + 1'b1;
            end
            2'b01:   credit_cnt_d = credit_cnt_q - 1'b1;
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

    assign in_flit   = flit_t'(in_data);
    assign is_outact = in_data_valid && (in_flit.ftype == FLIT_OUTACT);
    assign drop      = in_data_valid && (in_flit.ftype != FLIT_OUTACT);
    assign rx_pop    = host_rx_valid && host_rx_ready;
    assign rx_ovf    = is_outact && rx_full && !rx_pop;
    assign wr_entry  = '{pe: in_flit.pe, idx: in_flit.aux, data: in_flit.data};

    host_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (is_outact),
        .wr_data_i (wr_entry),
        .rd_en_i   (rx_pop),
        .rd_data_o (head),
        .full_o    (rx_full),
        .empty_o   (rx_empty)
    );

    assign host_rx_valid = !rx_empty;
    assign host_rx_pe    = head.pe;
    assign host_rx_idx   = head.idx;
    assign host_rx_data  = head.data;

    // Credits owed can briefly exceed one per cycle; the backlog drains one pulse per cycle.
    assign owed        = pend_q + PW'(rx_pop) + PW'(drop);
    assign up_credit_d = (owed != '0);
    assign pend_d      = owed - PW'(up_credit_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt_q <= CW'(TX_CREDITS);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            up_credit_q  <= 1'b0;
            pend_q       <= '0;
            err_q        <= '0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            out_valid_q  <= accept;
            if (accept) begin
                out_data_q <= ROUTER_WIDTH'(pack_flit(host_tx_type, host_tx_pe,
                                                     host_tx_aux, host_tx_data));
            end
            up_credit_q  <= up_credit_d;
            pend_q       <= pend_d;
            err_q        <= err_q | {cred_ovf, rx_ovf};
        end
    end

    assign out_data_valid  = out_valid_q;
    assign out_data        = out_data_q;
    assign upstream_credit = up_credit_q;
    assign err             = err_q;

endmodule

// File: tb/tb_host_network_interface.sv
// Scoreboard bench for host_network_interface: directed stimulus with
// hand-computed flits, monitors pop expected values on DUT outputs.
module tb_host_network_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_tx_valid = 1'b0;
    logic        host_tx_ready;
    logic [1:0]  host_tx_type = '0;
    logic [5:0]  host_tx_pe = '0;
    logic [7:0]  host_tx_aux = '0;
    logic [15:0] host_tx_data = '0;
    logic        host_rx_valid;
    logic        host_rx_ready = 1'b0;
    logic [5:0]  host_rx_pe;
    logic [7:0]  host_rx_idx;
    logic [15:0] host_rx_data;
    logic        out_data_valid;
    logic [31:0] out_data;
    logic        downstream_credit = 1'b0;
    logic        in_data_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        upstream_credit;
    logic [1:0]  err;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    bit chk_timing = 1'b0;
    bit prev_pop = 1'b0;

    logic [31:0] tx_q[$];
    logic [29:0] rx_q[$];

    host_network_interface dut (
        .clk               (clk),
        .rst               (rst),
        .host_tx_valid     (host_tx_valid),
        .host_tx_ready     (host_tx_ready),
        .host_tx_type      (host_tx_type),
        .host_tx_pe        (host_tx_pe),
        .host_tx_aux       (host_tx_aux),
        .host_tx_data      (host_tx_data),
        .host_rx_valid     (host_rx_valid),
        .host_rx_ready     (host_rx_ready),
        .host_rx_pe        (host_rx_pe),
        .host_rx_idx       (host_rx_idx),
        .host_rx_data      (host_rx_data),
        .out_data_valid    (out_data_valid),
        .out_data          (out_data),
        .downstream_credit (downstream_credit),
        .in_data_valid     (in_data_valid),
        .in_data           (in_data),
        .upstream_credit   (upstream_credit),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_data_valid) begin
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got flit %0h expected none", out_data);
                end else begin
                    check("tx_flit", out_data, tx_q.pop_front());
                end
            end
            if (host_rx_valid && host_rx_ready) begin
                if (rx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rx_unexpected: got idx %0h expected none", host_rx_idx);
                end else begin
                    check("rx_entry", {host_rx_pe, host_rx_idx, host_rx_data},
                          rx_q.pop_front());
                end
            end
            if (upstream_credit) begin
                pulses++;
                if (chk_timing) check("credit_after_pop", prev_pop, 1);
            end
            prev_pop = host_rx_valid && host_rx_ready;
        end
    end

    task automatic send_tx(input logic [1:0] t, input logic [5:0] pe,
                           input logic [7:0] aux, input logic [15:0] d,
                           input logic [31:0] expf, output int n);
        n = 0;
        host_tx_valid = 1'b1;
        host_tx_type  = t;
        host_tx_pe    = pe;
        host_tx_aux   = aux;
        host_tx_data  = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!host_tx_ready) break;
            tx_q.push_back(expf);
            n++;
            @(posedge clk);
            #1;
        end
        host_tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] f);
        @(posedge clk);
        #1;
        in_data_valid = 1'b1;
        in_data       = f;
    endtask

    task automatic rx_idle();
        @(posedge clk);
        #1;
        in_data_valid = 1'b0;
        in_data       = '0;
    endtask

    initial begin
        int n;
        int p0;

        #12;
        check("rst_out_valid", out_data_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_up_credit", upstream_credit, 0);
        check("rst_err", err, 0);
        check("rst_rx_valid", host_rx_valid, 0);
        check("rst_tx_ready", host_tx_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // reserved host type is never accepted
        @(posedge clk);
        #1;
        host_tx_valid = 1'b1;
        host_tx_type  = 2'd3;
        @(negedge clk);
        check("type3_ready", host_tx_ready, 0);
        @(posedge clk);
        #1;

        // five config commands against four credits
        host_tx_type = 2'd0;
        host_tx_pe   = 6'd2;
        host_tx_aux  = 8'd1;
        host_tx_data = 16'h0003;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (host_tx_ready) begin
                tx_q.push_back(32'h02010003);
                n++;
            end
            @(posedge clk);
            #1;
        end
        check("cfg_accepts", n, 4);
        @(negedge clk);
        check("cfg_ready_low", host_tx_ready, 0);
        check("cfg_err", err, 0);

        // one returned credit releases the pending 5th command
        @(posedge clk);
        #1;
        downstream_credit = 1'b1;
        @(posedge clk);
        #1;
        downstream_credit = 1'b0;
        @(negedge clk);
        check("credit_ready", host_tx_ready, 1);
        tx_q.push_back(32'h02010003);
        @(posedge clk);
        #1;
        host_tx_valid = 1'b0;
        @(negedge clk);
        check("credit_back_zero", host_tx_ready, 0);

        // reach two credits, then accept with a simultaneous credit
        @(posedge clk);
        #1;
        downstream_credit = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        host_tx_valid = 1'b1;
        host_tx_data  = 16'h0004;
        @(negedge clk);
        check("simul_ready", host_tx_ready, 1);
        tx_q.push_back(32'h02010004);
        @(posedge clk);
        #1;
        downstream_credit = 1'b0;
        send_tx(2'd1, 6'd9, 8'h22, 16'h1234, 32'h49221234, n);
        check("simul_credit_kept", n, 2);

        @(posedge clk);
        #1;
        downstream_credit = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        downstream_credit = 1'b0;
        @(negedge clk);
        check("refill_err", err, 0);

        // fill the rx FIFO, overflow it, and drop a non-result flit
        p0 = pulses;
        send_rx(32'hC5000100);
        rx_q.push_back({6'd5, 8'd0, 16'h0100});
        send_rx(32'hC5010101);
        rx_q.push_back({6'd5, 8'd1, 16'h0101});
        send_rx(32'hC5020102);
        rx_q.push_back({6'd5, 8'd2, 16'h0102});
        send_rx(32'hC5030103);
        rx_q.push_back({6'd5, 8'd3, 16'h0103});
        send_rx(32'hC5040104);
        send_rx(32'h01020003);
        rx_idle();
        @(negedge clk);
        check("ovf_err", err, 2'b01);
        check("head_valid", host_rx_valid, 1);
        check("head_idx", host_rx_idx, 0);
        check("head_pe", host_rx_pe, 5);
        check("head_data", host_rx_data, 16'h0100);
        @(negedge clk);
        check("drop_credit", pulses - p0, 1);

        // drain in order, one credit per pop
        chk_timing = 1'b1;
        p0 = pulses;
        @(posedge clk);
        #1;
        host_rx_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!host_rx_valid) break;
        end
        check("drain_done", host_rx_valid, 0);
        repeat (2) @(negedge clk);
        check("drain_credits", pulses - p0, 4);
        check("drain_queue", rx_q.size(), 0);
        check("ovf_sticky", err, 2'b01);
        chk_timing = 1'b0;

        // pop and drop in the same cycle give two back-to-back pulses
        send_rx(32'hC5090999);
        rx_q.push_back({6'd5, 8'd9, 16'h0999});
        send_rx(32'h00000000);
        rx_idle();
        @(negedge clk);
        check("dual_pulse1", upstream_credit, 1);
        @(negedge clk);
        check("dual_pulse2", upstream_credit, 1);
        @(negedge clk);
        check("dual_pulse_end", upstream_credit, 0);

        // credit return with a full counter
        @(posedge clk);
        #1;
        downstream_credit = 1'b1;
        @(posedge clk);
        #1;
        downstream_credit = 1'b0;
        @(negedge clk);
        check("credit_ovf_err", err, 2'b11);

        // reset with two results buffered
        host_rx_ready = 1'b0;
        send_rx(32'hC5000A00);
        send_rx(32'hC5010A01);
        rx_idle();
        @(negedge clk);
        check("pre_rst_valid", host_rx_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_rx_valid", host_rx_valid, 0);
        check("arst_out_valid", out_data_valid, 0);
        check("arst_err", err, 0);
        check("arst_tx_ready", host_tx_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_tx(2'd2, 6'h3F, 8'h07, 16'hBEEF, 32'hBF07BEEF, n);
        check("post_rst_credits", n, 4);
        check("post_rst_rx_empty", host_rx_valid, 0);

        repeat (3) @(negedge clk);
        check("tx_queue_empty", tx_q.size(), 0);
        check("rx_queue_empty", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
